// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply/divide sequencer that borrows the shared EX-stage ALU
// for its add/subtract steps; results land in the HI/LO registers.
//
//   state | meaning
//   IDLE  | waiting for start; ALU driven with idle values
//   RUN   | one shift-add (multu) or restoring-subtract (divu) step per cycle
//   DONE  | result final in hi/lo; done pulses for this single cycle
module muldiv_seq #(
  parameter int         WIDTH    = 32,
  parameter logic [3:0] FUNC_ADD = 4'b0010,
  parameter logic [3:0] FUNC_SUB = 4'b1010
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_func,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi_q, lo_q, opnd;
  logic             op_q;
  logic [WIDTH-1:0] sh;
  logic             ge, carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      opnd  <= '0;
      op_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        op_q <= op;
        opnd <= op ? src_b : src_a;
        hi_q <= '0;
        lo_q <= op ? src_a : src_b;
        cnt  <= '0;
      end else if (state == RUN) begin
        cnt <= cnt + CW'(1);
        if (op_q) begin
          hi_q <= ge ? alu_out : sh;
          lo_q <= {lo_q[WIDTH-2:0], ge};
        end else begin
          hi_q <= {carry, alu_out[WIDTH-1:1]};
          lo_q <= {alu_out[0], lo_q[WIDTH-1:1]};
        end
      end
    end
  end

  // Carry out of the ALU add is recovered by the wrap-around compare, since the ALU has no carry flag.
  always_comb begin
    sh        = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    ge        = hi_q[WIDTH-1] | (sh >= opnd);
    carry     = (alu_out < hi_q);
    alu_in1   = '0;
    alu_in2   = '0;
    alu_func  = FUNC_ADD;
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (op_q) begin
          alu_in1  = sh;
          alu_in2  = opnd;
          alu_func = FUNC_SUB;
        end else begin
          alu_in1 = hi_q;
          alu_in2 = lo_q[0] ? opnd : '0;
        end
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized and directed bench for muldiv_seq; the ALU is modelled here and results are
// checked against plain 64-bit multiply / divide arithmetic.
module tb_muldiv_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] src_a = '0, src_b = '0;
  logic [W-1:0] alu_in1, alu_in2, alu_out, hi, lo;
  logic [3:0]   alu_func;
  logic         busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_func(alu_func), .alu_out(alu_out),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Shared ALU: add or subtract, combinational.
  assign alu_out = (alu_func == 4'b1010) ? alu_in1 - alu_in2 : alu_in1 + alu_in2;

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void ref_model(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] r_hi, output logic [W-1:0] r_lo);
    longint unsigned p;
    if (!is_div) begin
      p    = longint'(a) * longint'(b);
      r_hi = p[63:32];
      r_lo = p[31:0];
    end else if (b == 0) begin
      r_hi = a;
      r_lo = '1;
    end else begin
      r_hi = a % b;
      r_lo = a / b;
    end
  endfunction

  // Issues one operation and checks timing, ALU func and result. inject_at pulses a second
  // start at that RUN cycle; reset_at pulls reset at that RUN cycle and ends the op there.
  task automatic do_op(input bit op_i, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int inject_at, input int reset_at);
    logic [W-1:0] e_hi, e_lo;
    int  n;
    bit  func_ok;
    ref_model(op_i, a, b, e_hi, e_lo);
    @(negedge clk);
    start = 1'b1; op = op_i; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    func_ok = 1'b1;
    while (busy && n < 100) begin
      if (alu_func !== (op_i ? 4'b1010 : 4'b0010)) func_ok = 1'b0;
      if (n == reset_at) begin
        rst_n = 1'b0;
        #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_hi", hi, 0);
        check_val("rst_lo", lo, 0);
        check_val("rst_in1", alu_in1, 0);
        check_val("rst_in2", alu_in2, 0);
        check_val("rst_func", alu_func, 4'b0010);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (n == inject_at) begin
        start = 1'b1; op = 1'b1; src_a = 9; src_b = 3;
      end else begin
        start = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    check_val("busy_cycles", n, W);
    check_val("alu_func_run", func_ok, 1);
    check_val("done_pulse", done, 1);
    check_val("busy_in_done", busy, 0);
    check_val("hi", hi, e_hi);
    check_val("lo", lo, e_lo);
  endtask

  initial begin
    #1;
    check_val("reset_busy", busy, 0);
    check_val("reset_done", done, 0);
    check_val("reset_hi", hi, 0);
    check_val("reset_lo", lo, 0);
    check_val("reset_func", alu_func, 4'b0010);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op(1'b0, 3, 5, -1, -1);
    @(negedge clk);
    check_val("done_one_cycle", done, 0);
    check_val("hold_lo", lo, 32'h0000000F);

    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
    do_op(1'b1, 100, 7, -1, -1);
    do_op(1'b1, 32'hFFFF_FFFF, 1, -1, -1);
    do_op(1'b1, 32'h0000_1234, 0, -1, -1);

    // Second start during RUN is ignored; the following op is issued right after done.
    do_op(1'b0, 6, 7, 10, -1);
    do_op(1'b1, 9, 3, -1, -1);

    do_op(1'b1, 1000, 3, -1, 15);
    do_op(1'b1, 1000, 3, -1, -1);

    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      b = (i % 3 == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
      do_op(1'(i % 2), a, b, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative unsigned multiply/divide sequencer (MULTU/DIVU) that reuses the shared ALU's add and subtract functions; it does not contain its own adder.
- Sits beside the EX stage. It drives the ALU's In1/In2/Func inputs and reads ALUout.
- Results go to the HI/LO registers.
- Each operation takes one start cycle, WIDTH iteration cycles and one done cycle.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- FUNC_ADD, 4'b0010, ALU Func code for A + B.
- FUNC_SUB, 4'b1010, ALU Func code for A - B.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; honoured only in IDLE.
- op  input  1  0 = multu, 1 = divu; sampled with start.
- src_a  input  WIDTH  multiplicand or dividend; sampled with start.
- src_b  input  WIDTH  multiplier or divisor; sampled with start.
- alu_in1  output  WIDTH  to ALU In1.
- alu_in2  output  WIDTH  to ALU In2.
- alu_func  output  4  to ALU Func.
- alu_out  input  WIDTH  from ALU ALUout (combinational, same cycle).
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when the result is final.
- hi  output  WIDTH  product high word or remainder.
- lo  output  WIDTH  product low word or quotient.

Behaviour:
- States: IDLE, RUN, DONE.
  - IDLE to RUN on start; src_a/src_b/op are latched and the 5-bit iteration counter is cleared.
  - RUN to DONE after iteration WIDTH-1, i.e. exactly WIDTH cycles in RUN.
  - DONE to IDLE unconditionally after one cycle.
- Reset (async, any state, including mid-operation): state=IDLE, counter=0, hi=0, lo=0, opnd=0, busy=0, done=0. The ALU outputs take their idle values.
- ALU drive in IDLE/DONE: alu_in1=0, alu_in2=0, alu_func=FUNC_ADD.
- Start latch:
  - Register opnd <= src_a (multu) or src_b (divu).
  - hi <= 0.
  - lo <= src_b (multu) or src_a (divu).
- Multiply iteration (one per RUN cycle):
  - alu_in1 = hi; alu_in2 = lo[0] ? opnd : 0; alu_func = FUNC_ADD.
  - carry = (alu_out < hi), unsigned compare.
  - hi <= {carry, alu_out[WIDTH-1:1]}; lo <= {alu_out[0], lo[WIDTH-1:1]}.
- Divide iteration (restoring):
  - sh = {hi[WIDTH-2:0], lo[WIDTH-1]}; top = hi[WIDTH-1].
  - alu_in1 = sh; alu_in2 = opnd; alu_func = FUNC_SUB.
  - ge = top | (sh >= opnd), unsigned compare.
  - hi <= ge ? alu_out : sh; lo <= {lo[WIDTH-2:0], ge}.
- Results:
  - After the last iteration, {hi,lo} = 2*WIDTH-bit product, or lo = quotient and hi = remainder.
  - hi/lo hold until the next accepted start or reset.
- Outputs: done is high only in DONE; busy is high only in RUN. Both are registered state decodes.
- Start in RUN or DONE is ignored: no restart and latched operands unchanged.
- Divide by zero is not special-cased. The algorithm yields lo = all ones and hi = dividend, and the bench checks exactly that.
- Back-to-back: start asserted in the cycle after done (IDLE) is accepted. Minimum issue interval is WIDTH+2 cycles.
- All arithmetic is unsigned modulo 2^WIDTH. No signed mode; sign handling belongs to the caller.

Test Plan:
- Small multiply: multu 3 x 5.
  - busy high for exactly 32 cycles; done one cycle later.
  - hi=0x00000000, lo=0x0000000F.
  - alu_func=0010 throughout RUN.
- Carry path: multu 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Divide: divu 100 / 7 -> lo=14, hi=2, with alu_func=1010 throughout RUN. Also divu 0xFFFFFFFF / 1 -> lo=0xFFFFFFFF, hi=0.
- Divide by zero: divu 0x00001234 / 0 -> lo=0xFFFFFFFF, hi=0x00001234.
- Start while busy: start multu 6 x 7, then pulse start with divu 9/3 at RUN cycle 10.
  - Second request ignored; result hi=0, lo=42.
  - A new start the cycle after done is accepted.
- Reset mid-operation: assert rst_n=0 at RUN cycle 15 of divu 1000/3.
  - Immediately (async): busy=0, done=0, hi=0, lo=0, alu_in1=alu_in2=0, alu_func=0010.
  - After release, divu 1000/3 runs to lo=333, hi=1.
